median_row_buffer: RTL and testbench
====================================

MEDIAN_ROW_BUFFER -- requirements
Module: median_row_buffer

Interface
REQ-001 Parameter WORDS_PER_ROW, default 4: 32-bit pixel words per image row (4 pixels/word); legal range 2..1024.
REQ-002 Parameter ROWS, default 4: rows per frame; legal range 3..4096.
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_word  in  32  four 8-bit pixels of the current raster-order input row.
REQ-006 in_valid  in  1  in_word is valid.
REQ-007 in_ready  out  1  block accepts in_word this cycle.
REQ-008 word0  out  32  pixel word from row r-2, same column.
REQ-009 word1  out  32  pixel word from row r-1, same column.
REQ-010 word2  out  32  pixel word from row r (the just-accepted word).
REQ-011 out_valid  out  1  word0..word2 form a valid vertical triple.
REQ-012 out_ready  in  1  downstream median stage consumes the triple.
REQ-013 out_last  out  1  qualifies the final triple of a frame.
REQ-014 frame_done  out  1  one-cycle pulse after the last input word of a frame is accepted.

Function
REQ-015 An input is accepted when in_valid && in_ready; only accepted words advance col/row counters.
REQ-016 in_ready SHALL equal !out_valid || out_ready (single-register pipe, no skid buffer).
REQ-017 Counters: col 0..WORDS_PER_ROW-1, row 0..ROWS-1; col wraps to 0 and row increments on the last column; row wraps to 0 after ROWS-1.
REQ-018 FSM states FILL (row < 2) and STREAM (row >= 2); FILL->STREAM on acceptance of row 1 last column; STREAM->FILL on acceptance of last word of the frame.
REQ-019 On every accepted word at column c: line0[c] <= line1[c], line1[c] <= in_word.
REQ-020 In STREAM, an accepted word loads word0 <= line0[c], word1 <= line1[c], word2 <= in_word (values before the REQ-019 update) and sets out_valid next cycle; latency exactly 1 cycle.
REQ-021 In FILL, accepted words update line storage only; no output triple is produced and out_valid clears if its triple is consumed.
REQ-022 out_valid, word0..word2 and out_last SHALL hold stable while out_valid && !out_ready.
REQ-023 out_valid clears on out_ready when no new STREAM word is accepted that cycle; simultaneous consume and accept reloads the register without a bubble.
REQ-024 out_last asserts with the triple produced from row ROWS-1, column WORDS_PER_ROW-1.
REQ-025 frame_done pulses the cycle after that final word is accepted, independent of out_ready.
REQ-026 Pixel data is passed through unmodified; no arithmetic on pixel bits.

Reset
REQ-027 While rst is high: out_valid=0, out_last=0, frame_done=0, word0..word2=0, col=0, row=0, state=FILL; in_ready=1 the first cycle after rst deasserts.
REQ-028 Reset mid-frame discards the partial frame; the next accepted word is row 0 col 0; line storage contents are not cleared (FILL overwrites them).

Structure
REQ-029 Shared package median_pkg holds PIX_W=8, PIX_PER_WORD=4, WORD_W=32 and the FILL/STREAM state enum.
REQ-030 Line storage is one sub-module median_line_ram: two WORDS_PER_ROW x 32 arrays, combinational read at address col, synchronous write of both lines on accept.
REQ-031 Counter widths derive from clog2 of WORDS_PER_ROW and ROWS.

Verification (WORDS_PER_ROW=4, ROWS=4, input word value = 16*row+col, out_ready=1 unless noted)
REQ-032 Fill: stream 8 words (rows 0-1) -> out_valid stays 0; word at row2 col0 -> next cycle word0=0x00, word1=0x10, word2=0x20, out_valid=1.
REQ-033 Full frame: 16 continuous words -> 8 triples in order, row3 col3 triple = (0x13,0x23,0x33) with out_last=1; frame_done pulses once.
REQ-034 Backpressure: out_ready=0 for 3 cycles during row 2 -> in_ready=0, outputs held stable, no word lost or duplicated after release.
REQ-035 Back-to-back frames: second frame values +0x100 -> its first 8 words produce no output; row2 col0 triple = (0x100,0x110,0x120).
REQ-036 Reset mid-row: rst at row2 col1, then fresh frame -> no output until row2 col0 of the new frame; out_valid=0 during and after reset.
REQ-037 in_valid gaps: random idle cycles -> output sequence identical to REQ-033.

Source files
------------

// File: rtl/median_pkg.sv
// Shared constants and state type for the median filter row-buffer slice.
// A word carries four 8-bit pixels, always treated as opaque data.
package median_pkg;

  localparam int PIX_W        = 8;
  localparam int PIX_PER_WORD = 4;
  localparam int WORD_W       = PIX_W * PIX_PER_WORD;

  // FILL: rows 0 and 1 are only buffered; STREAM: rows >= 2 emit vertical triples.
  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } state_t;

endpackage

// File: rtl/median_line_ram.sv
// Two line memories holding rows r-2 and r-1, read combinationally at the
// current column and shifted (line1 -> line0, new word -> line1) on accept.
module median_line_ram
  import median_pkg::*;
#(
  parameter int WORDS_PER_ROW = 4
) (
  input  logic                             clk,
  input  logic [$clog2(WORDS_PER_ROW)-1:0] addr,
  input  logic                             wr_en,
  input  logic [WORD_W-1:0]                wr_data,
  output logic [WORD_W-1:0]                rd0,
  output logic [WORD_W-1:0]                rd1
);

  logic [WORD_W-1:0] line0 [WORDS_PER_ROW];
  logic [WORD_W-1:0] line1 [WORDS_PER_ROW];

  assign rd0 = line0[addr];
  assign rd1 = line1[addr];

  // Contents are deliberately not reset: the FILL rows of every frame overwrite them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      line0[addr] <= line1[addr];
      line1[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/median_row_buffer.sv
// Raster row buffer that presents the same column of rows r-2, r-1 and r
// as one registered triple for a downstream vertical median stage.
module median_row_buffer
  import median_pkg::*;
#(
  parameter int WORDS_PER_ROW = 4,
  parameter int ROWS          = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_word,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WORD_W-1:0] word0,
  output logic [WORD_W-1:0] word1,
  output logic [WORD_W-1:0] word2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              frame_done
);

  localparam int COL_W = $clog2(WORDS_PER_ROW);
  localparam int ROW_W = $clog2(ROWS);

  localparam logic [COL_W-1:0] LAST_COL      = COL_W'(WORDS_PER_ROW - 1);
  localparam logic [ROW_W-1:0] LAST_ROW      = ROW_W'(ROWS - 1);
  localparam logic [ROW_W-1:0] LAST_FILL_ROW = ROW_W'(1);

  state_t            state;
  state_t            state_next;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic              accept;
  logic              at_last_col;
  logic              end_of_fill;
  logic              end_of_frame;
  logic              load_triple;
  logic [WORD_W-1:0] line0_rd;
  logic [WORD_W-1:0] line1_rd;

  // Single output register with no skid: new input only when the slot is free.
  assign in_ready     = !out_valid || out_ready;
  assign accept       = in_valid && in_ready;
  assign at_last_col  = (col == LAST_COL);
  assign end_of_fill  = at_last_col && (row == LAST_FILL_ROW);
  assign end_of_frame = at_last_col && (row == LAST_ROW);

  median_line_ram #(
    .WORDS_PER_ROW(WORDS_PER_ROW)
  ) u_line_ram (
    .clk    (clk),
    .addr   (col),
    .wr_en  (accept),
    .wr_data(in_word),
    .rd0    (line0_rd),
    .rd1    (line1_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    load_triple = 1'b0;
    case (state)
      FILL: begin
        if (accept && end_of_fill) begin
          state_next = STREAM;
        end
      end
      STREAM: begin
        load_triple = accept;
        if (accept && end_of_frame) begin
          state_next = FILL;
        end
      end
      default: begin
        state_next = FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (at_last_col) begin
        col <= '0;
        row <= (row == LAST_ROW) ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Line reads are taken before this cycle's shift, so they hold rows r-2 and r-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      word0     <= '0;
      word1     <= '0;
      word2     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (load_triple) begin
      word0     <= line0_rd;
      word1     <= line1_rd;
      word2     <= in_word;
      out_valid <= 1'b1;
      out_last  <= end_of_frame;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && end_of_frame;
    end
  end

endmodule

// File: tb/tb_median_row_buffer.sv
// Self-checking bench for median_row_buffer: a fixed vector table for one frame,
// then scoreboarded sequences checked against a whole-frame image model.
module tb_median_row_buffer;
  import median_pkg::*;

  localparam int W     = 4;
  localparam int R     = 4;
  localparam int FRAME = W * R;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_word;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] word0;
  logic [31:0] word1;
  logic [31:0] word2;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        frame_done;

  always #5 clk = ~clk;

  median_row_buffer #(
    .WORDS_PER_ROW(W),
    .ROWS         (R)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_word   (in_word),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .word0     (word0),
    .word1     (word1),
    .word2     (word2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .frame_done(frame_done)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic        last;
  } triple_t;

  typedef struct {
    logic [31:0] word;
    logic        valid;
    logic        ordy;
    logic        exp_valid;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        exp_last;
    logic        exp_fd;
  } vec_t;

  // Reference model: the full image of the current frame plus expected triples.
  triple_t     exp_q[$];
  logic [31:0] img [R][W];
  int          k;
  int          acc_count;
  logic [31:0] base;
  logic [31:0] base_step;
  logic        hold_pending;
  triple_t     hold_val;
  logic        fd_expect;
  vec_t        vecs [FRAME+1];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pix_word(input int idx);
    return base + 32'(16 * (idx / W) + (idx % W));
  endfunction

  task automatic model_reset();
    exp_q.delete();
    k            = 0;
    acc_count    = 0;
    hold_pending = 1'b0;
    fd_expect    = 1'b0;
  endtask

  // One clock of scoreboarded traffic; inputs change one time unit after the edge.
  task automatic apply_stimulus(input logic v, input logic ordy);
    triple_t t;
    logic    acc;
    int      r;
    int      c;
    in_valid  = v;
    out_ready = ordy;
    in_word   = pix_word(k);
    #1;
    check_output("in_ready", in_ready, (out_valid && !out_ready) ? 1'b0 : 1'b1);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_triple", 1'b1, 1'b0);
      end else begin
        t = exp_q.pop_front();
        check_output("triple_word0", word0, t.w0);
        check_output("triple_word1", word1, t.w1);
        check_output("triple_word2", word2, t.w2);
        check_output("triple_last", out_last, t.last);
      end
    end
    hold_pending = out_valid && !out_ready;
    hold_val     = '{word0, word1, word2, out_last};
    acc          = in_valid && in_ready;
    fd_expect    = 1'b0;
    if (acc) begin
      r = k / W;
      c = k % W;
      if (r >= 2) begin
        exp_q.push_back('{img[r-2][c], img[r-1][c], in_word, (k == FRAME - 1)});
      end
      img[r][c] = in_word;
      fd_expect = (k == FRAME - 1);
      k         = (k + 1) % FRAME;
      acc_count++;
      if (k == 0) begin
        base = base + base_step;
      end
    end
    @(posedge clk);
    #1;
    check_output("frame_done", frame_done, fd_expect);
    check_output("out_valid", out_valid, (exp_q.size() != 0) ? 1'b1 : 1'b0);
    if (exp_q.size() > 1) begin
      check_output("triple_backlog", 32'(exp_q.size()), 32'd1);
    end
    if (hold_pending) begin
      check_output("hold_valid", out_valid, 1'b1);
      check_output("hold_word0", word0, hold_val.w0);
      check_output("hold_word1", word1, hold_val.w1);
      check_output("hold_word2", word2, hold_val.w2);
      check_output("hold_last", out_last, hold_val.last);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_output("rst_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_word   = '0;
    base      = '0;
    base_step = '0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_out_valid", out_valid, 1'b0);
    check_output("rst_out_last", out_last, 1'b0);
    check_output("rst_frame_done", frame_done, 1'b0);
    check_output("rst_word0", word0, 32'h0);
    check_output("rst_word1", word1, 32'h0);
    check_output("rst_word2", word2, 32'h0);
    rst = 1'b0;
    #1;
    check_output("post_rst_in_ready", in_ready, 1'b1);

    // One continuous frame from a fixed table, word = 16*row+col
    for (int i = 0; i <= FRAME; i++) begin
      int r;
      int c;
      r = i / W;
      c = i % W;
      vecs[i].word      = 32'(16 * r + c);
      vecs[i].valid     = (i < FRAME);
      vecs[i].ordy      = 1'b1;
      vecs[i].exp_valid = (i < FRAME) && (r >= 2);
      vecs[i].e0        = 32'(16 * (r - 2) + c);
      vecs[i].e1        = 32'(16 * (r - 1) + c);
      vecs[i].e2        = 32'(16 * r + c);
      vecs[i].exp_last  = (i == FRAME - 1);
      vecs[i].exp_fd    = (i == FRAME - 1);
    end
    for (int i = 0; i <= FRAME; i++) begin
      in_word   = vecs[i].word;
      in_valid  = vecs[i].valid;
      out_ready = vecs[i].ordy;
      @(posedge clk);
      #1;
      check_output($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        check_output($sformatf("vec%0d_word0", i), word0, vecs[i].e0);
        check_output($sformatf("vec%0d_word1", i), word1, vecs[i].e1);
        check_output($sformatf("vec%0d_word2", i), word2, vecs[i].e2);
      end
      check_output($sformatf("vec%0d_out_last", i), out_last, vecs[i].exp_last);
      check_output($sformatf("vec%0d_frame_done", i), frame_done, vecs[i].exp_fd);
    end

    // Backpressure: out_ready low for three cycles during row 2
    do_reset();
    base      = '0;
    base_step = '0;
    for (n = 0; n < FRAME + 8; n++) begin
      apply_stimulus(acc_count < FRAME, !(n >= 9 && n <= 11));
    end
    check_output("bp_accepted", 32'(acc_count), 32'(FRAME));
    check_output("bp_drained", 32'(exp_q.size()), 32'd0);

    // Back-to-back frames, second frame offset by 0x100
    do_reset();
    base      = '0;
    base_step = 32'h100;
    for (n = 0; n < 100 && acc_count < 2 * FRAME; n++) begin
      apply_stimulus(1'b1, 1'b1);
    end
    check_output("b2b_accepted", 32'(acc_count), 32'(2 * FRAME));
    apply_stimulus(1'b0, 1'b1);
    check_output("b2b_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-row at row 2 col 1, then a fresh frame
    do_reset();
    base      = '0;
    base_step = '0;
    for (n = 0; n < 50 && acc_count < 2 * W + 2; n++) begin
      apply_stimulus(1'b1, 1'b0);
    end
    rst      = 1'b1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      check_output("midrst_out_valid", out_valid, 1'b0);
    end
    rst = 1'b0;
    model_reset();
    base = 32'h200;
    #1;
    check_output("midrst_after_valid", out_valid, 1'b0);
    for (n = 0; n < 100 && acc_count < FRAME; n++) begin
      apply_stimulus(1'b1, 1'b1);
    end
    check_output("midrst_accepted", 32'(acc_count), 32'(FRAME));

    // Random idle gaps on both sides over three frames
    do_reset();
    base      = '0;
    base_step = '0;
    for (n = 0; n < 2000 && acc_count < 3 * FRAME; n++) begin
      apply_stimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end
    check_output("rand_accepted", 32'(acc_count), 32'(3 * FRAME));
    repeat (3) apply_stimulus(1'b0, 1'b1);
    check_output("rand_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
